// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_pkg
// Description : Shared command codes, frame size, FSM state type and a
//               frame-builder helper for the SPI serial-SRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_sram_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 40;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Command, byte address of the word, then two data bytes. Reads clock out
    // zero dummy bytes while the SRAM returns data.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        we,
        input logic [11:0] addr,
        input logic [15:0] wdata
    );
        logic [7:0]  cmd;
        logic [15:0] data;
        cmd  = we ? CMD_WRITE : CMD_READ;
        data = we ? wdata : 16'h0000;
        return {cmd, 3'b000, addr, 1'b0, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_bridge_if
// Description : CPU-side word request/response bus of the SPI SRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_sram_bridge_if;

    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        done;

    modport master (
        output req, we, addr, wdata,
        input  rdata, busy, done
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/spi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_tick_gen
// Description : Half-period tick generator. Produces a single-cycle tick
//               every CLK_DIV enabled clk cycles; clr restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Free-running divider while enabled, wrapping on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_bridge
// Description : Turns one 16-bit word read/write request into a complete
//               SPI mode-0 frame (cmd, 16-bit byte address, two data bytes)
//               to a 23LC-style serial SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sram_bridge
    import spi_sram_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_sram_bridge_if.slave    bus,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic                spi_cs_n
);

    state_t                  state;
    logic                    we_q;
    logic [FRAME_BITS-1:0]   tx_sr;
    logic [15:0]             rx_sr;
    logic [5:0]              bit_cnt;
    logic [15:0]             rdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    tick;
    logic [FRAME_BITS-1:0]   frame_load;

    assign frame_load = build_frame(bus.we, bus.addr, bus.wdata);

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // Divider is held clear in IDLE so every frame starts on a fresh count.
    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    // Frame sequencer: accept, CS setup, 40-bit shift, CS release, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        tx_sr    <= frame_load;
                        rx_sr    <= '0;
                        bit_cnt  <= '0;
                        spi_mosi <= frame_load[FRAME_BITS-1];
                        spi_cs_n <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!spi_sclk) begin
                            // Rising edge: sample, except during write data bytes.
                            spi_sclk <= 1'b1;
                            if (!(we_q && (bit_cnt >= 6'd24))) begin
                                rx_sr <= {rx_sr[14:0], spi_miso};
                            end
                            bit_cnt <= bit_cnt + 6'd1;
                        end else begin
                            // Falling edge: present the next bit, or finish.
                            spi_sclk <= 1'b0;
                            if (bit_cnt == 6'(FRAME_BITS)) begin
                                state <= HOLD;
                            end else begin
                                tx_sr    <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                                spi_mosi <= tx_sr[FRAME_BITS-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= rx_sr;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sram_bridge
// Description : Scoreboard bench for spi_sram_bridge. DUT 0 runs at
//               CLK_DIV=2, DUT 1 at CLK_DIV=1; a serial-SRAM model answers
//               on miso and a per-DUT monitor checks each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sram_bridge;

    typedef struct {
        int          inst;
        logic [39:0] frame;
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [1:0]       req_v, we_v;
    logic [1:0][11:0] addr_v;
    logic [1:0][15:0] wdata_v;
    logic [1:0][39:0] resp_v;
    logic [1:0]       busy_v, done_v, sclk_v, mosi_v, cs_n_v;
    logic [1:0][15:0] rdata_v;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 2 : 1;

        spi_sram_bridge_if bus ();

        logic        sclk_w, mosi_w, cs_n_w, miso_w;
        int          rises = 0;
        int          last_rise = 0;
        logic [39:0] frame = '0;
        logic        busy_q = 1'b0;
        logic        done_q = 1'b0;
        logic        cs_q = 1'b1;
        logic        seen = 1'b0;
        int          acc_cyc = 0;
        int          cs_hi = 0;

        assign bus.req    = req_v[g];
        assign bus.we     = we_v[g];
        assign bus.addr   = addr_v[g];
        assign bus.wdata  = wdata_v[g];
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign rdata_v[g] = bus.rdata;
        assign sclk_v[g]  = sclk_w;
        assign mosi_v[g]  = mosi_w;
        assign cs_n_v[g]  = cs_n_w;

        // SRAM model: bit k of the frame answers with resp[39-k].
        assign miso_w = (rises < 40) ? resp_v[g][39 - rises] : 1'b0;

        spi_sram_bridge #(
            .CLK_DIV (DIV)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus),
            .spi_sclk (sclk_w),
            .spi_mosi (mosi_w),
            .spi_miso (miso_w),
            .spi_cs_n (cs_n_w)
        );

        // Capture mosi on each sclk rise; restart on chip-select assertion.
        always @(posedge sclk_w or negedge cs_n_w) begin
            if (!cs_n_w && sclk_w) begin
                frame = {frame[38:0], mosi_w};
                if (rises > 0)
                    chk($sformatf("dut%0d_sclk_period", g), 64'(cyc - last_rise), 64'(2 * DIV));
                last_rise = cyc;
                rises++;
            end else if (!cs_n_w) begin
                rises = 0;
                frame = '0;
            end
        end

        // Response monitor: pops the scoreboard on every done pulse.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                busy_q = 1'b0;
                done_q = 1'b0;
                cs_q   = 1'b1;
                cs_hi  = 0;
            end else begin
                if (bus.busy && !busy_q) acc_cyc = cyc;
                if (done_q) chk($sformatf("dut%0d_done_width", g), 64'(bus.done), 64'(0));
                if (bus.done) begin
                    chk($sformatf("dut%0d_busy_at_done", g), 64'(bus.busy), 64'(0));
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d_unexpected_done: got a done pulse, required none", g);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("dut%0d_inst", g), 64'(e.inst), 64'(g));
                        chk($sformatf("dut%0d_frame", g), 64'(frame), 64'(e.frame));
                        chk($sformatf("dut%0d_rise_count", g), 64'(rises), 64'(40));
                        chk($sformatf("dut%0d_latency", g), 64'(cyc - acc_cyc), 64'(e.lat));
                        chk($sformatf("dut%0d_rdata", g), 64'(bus.rdata), 64'(e.rdata));
                    end
                end
                if (cs_n_w) begin
                    cs_hi++;
                end else if (cs_q) begin
                    if (seen) chk($sformatf("dut%0d_cs_gap", g), 64'(cs_hi >= 1), 64'(1));
                    seen  = 1'b1;
                    cs_hi = 0;
                end
                busy_q = bus.busy;
                done_q = bus.done;
                cs_q   = cs_n_w;
            end
        end
    end

    task automatic issue(input int k, input logic w, input logic [11:0] a,
                         input logic [15:0] d, input logic [39:0] resp);
        resp_v[k]  = resp;
        we_v[k]    = w;
        addr_v[k]  = a;
        wdata_v[k] = d;
        req_v[k]   = 1'b1;
        @(negedge clk);
        req_v[k] = 1'b0;
        chk($sformatf("dut%0d_accept_busy", k), 64'(busy_v[k]), 64'(1));
    endtask

    task automatic wait_done(input int k, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_v[k]) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d_done_timeout: got no done in %0d cycles, required one", k, max_cyc);
    endtask

    task automatic run(input int k, input logic w, input logic [11:0] a, input logic [15:0] d,
                       input logic [39:0] resp, input logic [39:0] frm,
                       input logic [15:0] rd, input int lat);
        exp_t e;
        e.inst  = k;
        e.frame = frm;
        e.rdata = rd;
        e.lat   = lat;
        sb.push_back(e);
        issue(k, w, a, d, resp);
        wait_done(k, lat + 20);
    endtask

    initial begin
        exp_t e;
        int   r;
        logic prev;
        rst_n   = 1'b0;
        req_v   = '0;
        we_v    = '0;
        addr_v  = '0;
        wdata_v = '0;
        resp_v  = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d_rst_busy", k), 64'(busy_v[k]), 64'(0));
            chk($sformatf("dut%0d_rst_done", k), 64'(done_v[k]), 64'(0));
            chk($sformatf("dut%0d_rst_sclk", k), 64'(sclk_v[k]), 64'(0));
            chk($sformatf("dut%0d_rst_mosi", k), 64'(mosi_v[k]), 64'(0));
            chk($sformatf("dut%0d_rst_cs_n", k), 64'(cs_n_v[k]), 64'(1));
            chk($sformatf("dut%0d_rst_rdata", k), 64'(rdata_v[k]), 64'(0));
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 123 <- BEEF: 02 02 46 BE EF.
        run(0, 1'b1, 12'h123, 16'hBEEF, 40'hFF_FFFF_FFFF, 40'h02_0246_BEEF, 16'h0000, 165);
        repeat (3) @(negedge clk);
        // Read FFF: 03 1F FE, SRAM returns A5 5A.
        run(0, 1'b0, 12'hFFF, 16'h0000, 40'hFF_FFFF_A55A, 40'h03_1FFE_0000, 16'hA55A, 165);
        repeat (3) @(negedge clk);
        // Write leaves rdata alone.
        run(0, 1'b1, 12'h0A5, 16'h1234, 40'hFF_FFFF_FFFF, 40'h02_014A_1234, 16'hA55A, 165);
        repeat (3) @(negedge clk);

        // Read 234 with a stray request mid-frame.
        e.inst  = 0;
        e.frame = 40'h03_0468_0000;
        e.rdata = 16'h3C96;
        e.lat   = 165;
        sb.push_back(e);
        issue(0, 1'b0, 12'h234, 16'h0000, 40'hFF_FFFF_3C96);
        repeat (30) @(negedge clk);
        we_v[0]    = 1'b1;
        addr_v[0]  = 12'h001;
        wdata_v[0] = 16'hFFFF;
        req_v[0]   = 1'b1;
        repeat (2) @(negedge clk);
        req_v[0] = 1'b0;
        wait_done(0, 200);
        repeat (10) @(negedge clk);

        // Abort a read at bit 20 with asynchronous reset.
        issue(0, 1'b0, 12'h7FF, 16'h0000, 40'hFF_FFFF_1111);
        r    = 0;
        prev = 1'b0;
        for (int i = 0; i < 300 && r < 20; i++) begin
            @(negedge clk);
            if (sclk_v[0] && !prev) r++;
            prev = sclk_v[0];
        end
        chk("abort_reached_bit20", 64'(r), 64'(20));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(cs_n_v[0]), 64'(1));
        chk("abort_sclk", 64'(sclk_v[0]), 64'(0));
        chk("abort_busy", 64'(busy_v[0]), 64'(0));
        chk("abort_rdata", 64'(rdata_v[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);

        // Normal read after the abort.
        run(0, 1'b0, 12'h800, 16'h0000, 40'hFF_FFFF_C3E1, 40'h03_1000_0000, 16'hC3E1, 165);
        repeat (3) @(negedge clk);

        // CLK_DIV=1: two back-to-back reads.
        run(1, 1'b0, 12'h010, 16'h0000, 40'hFF_FFFF_8001, 40'h03_0020_0000, 16'h8001, 83);
        run(1, 1'b0, 12'hABC, 16'h0000, 40'h00_0000_7E18, 40'h03_1578_0000, 16'h7E18, 83);
        repeat (10) @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
